// File: rtl/sram_word_controller.sv
// Word-to-beat controller for an asynchronous SRAM: one DATA_W access becomes DATA_W/SRAM_DW beats.
// Optional one-entry read buffer is built when SRAM_READ_BUFFER_EN is defined.
module sram_word_controller #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   read_data,
    output logic                ready,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ
);
    localparam int BEATS   = DATA_W / SRAM_DW;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        LAST_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [3:0]          wait_q;
    logic                is_wr_q;
    logic [DATA_W-1:0]   wsh_q;
    logic [DATA_W-1:0]   rsh_q;
    logic [DATA_W-1:0]   read_data_q;
    logic [SRAM_AW-1:0]  addr_q;
    logic                we_n_q;
    logic                oe_n_q;
    logic                drive_q;

    logic                req_s;
    logic                start_s;
    logic                last_wait_s;
    logic                last_beat_s;
    logic                done_edge_s;
    logic                hit_s;
    logic [DATA_W-1:0]   hit_data_s;
    logic [31:0]         off_s;
    logic [31:0]         word_s;
    logic [SRAM_AW-1:0]  base_s;
    logic [DATA_W-1:0]   dq_ext_s;
    logic [DATA_W-1:0]   rsh_next_s;

    assign req_s       = mem_r_en | mem_w_en;
    assign start_s     = (state_q == IDLE) && req_s && !hit_s;
    assign last_wait_s = (wait_q == LAST_WAIT);
    assign last_beat_s = (beat_q == LAST_BEAT);
    assign done_edge_s = (state_q == ACCESS) && last_wait_s && last_beat_s;
    assign off_s       = address - 32'(BASE_ADDR);
    assign word_s      = off_s >> BYTE_SH;
    assign base_s      = SRAM_AW'(word_s * 32'(BEATS));

    // Each sampled beat enters at the top, so beat 0 ends up least significant after BEATS shifts.
    assign dq_ext_s    = DATA_W'(SRAM_DQ);
    assign rsh_next_s  = (rsh_q >> SRAM_DW) | (dq_ext_s << (DATA_W - SRAM_DW));

`ifdef SRAM_READ_BUFFER_EN
    logic                buf_valid_q;
    logic [SRAM_AW-1:0]  buf_addr_q;
    logic [SRAM_AW-1:0]  base_q;
    logic [DATA_W-1:0]   buf_data_q;

    assign hit_s      = (state_q == IDLE) && buf_valid_q && mem_r_en && !mem_w_en &&
                        (buf_addr_q == base_s);
    assign hit_data_s = buf_data_q;

    // Read buffer: filled by completed reads, kept coherent by writes to the same SRAM word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            base_q      <= '0;
            buf_data_q  <= '0;
        end else if (start_s) begin
            base_q <= base_s;
            if (mem_w_en && buf_valid_q && (buf_addr_q == base_s)) begin
                buf_data_q <= write_data;
            end
        end else if (done_edge_s && !is_wr_q) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= base_q;
            buf_data_q  <= rsh_next_s;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_data_s = '0;
`endif

    // Access sequencer: beat/wait counting and registered SRAM strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wait_q      <= 4'd0;
            is_wr_q     <= 1'b0;
            wsh_q       <= '0;
            rsh_q       <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b0;
            drive_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        state_q <= ACCESS;
                        beat_q  <= '0;
                        wait_q  <= 4'd0;
                        is_wr_q <= mem_w_en;
                        wsh_q   <= write_data;
                        addr_q  <= base_s;
                        we_n_q  <= !mem_w_en;
                        oe_n_q  <= mem_w_en;
                        drive_q <= mem_w_en;
                    end else if (hit_s) begin
                        read_data_q <= hit_data_s;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (last_wait_s) begin
                        if (!is_wr_q) begin
                            rsh_q <= rsh_next_s;
                        end
                        if (last_beat_s) begin
                            state_q <= DONE;
                            we_n_q  <= 1'b1;
                            oe_n_q  <= 1'b0;
                            drive_q <= 1'b0;
                            if (!is_wr_q) begin
                                read_data_q <= rsh_next_s;
                            end
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                            wait_q <= 4'd0;
                            addr_q <= addr_q + SRAM_AW'(1);
                            wsh_q  <= wsh_q >> SRAM_DW;
                            we_n_q <= !is_wr_q;
                        end
                    end else begin
                        // The strobe rises for the final cycle of the beat so data is held past WE_N.
                        wait_q <= wait_q + 4'd1;
                        we_n_q <= !(is_wr_q && ((wait_q + 4'd1) != LAST_WAIT));
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                    wait_q  <= 4'd0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = !reset || (state_q == DONE) || ((state_q == IDLE) && (!req_s || hit_s));
    assign read_data = hit_s ? hit_data_s : read_data_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ   = drive_q ? wsh_q[SRAM_DW-1:0] : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_word_controller.sv
// Scoreboarded bench: random word reads/writes against a word-level memory model, plus a 64/16 zero-wait instance.
module tb_sram_word_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        r_en, w_en;
    logic [31:0] addr, wdata, rdata;
    logic        rdy, ub_n, lb_n, ce_n, oe_n, we_n;
    logic [17:0] sa;
    wire  [15:0] dq;

    logic        r64, w64;
    logic [31:0] addr64;
    logic [63:0] wdata64, rdata64;
    logic        rdy64, ub64, lb64, ce64, oe64, we64;
    logic [17:0] sa64;
    wire  [15:0] dq64;

    always #5 clk = ~clk;

    sram_word_controller dut (
        .clk(clk), .reset(reset), .mem_r_en(r_en), .mem_w_en(w_en), .address(addr),
        .write_data(wdata), .read_data(rdata), .ready(rdy), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_ADDR(sa), .SRAM_DQ(dq)
    );

    sram_word_controller #(.DATA_W(64), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut64 (
        .clk(clk), .reset(reset), .mem_r_en(r64), .mem_w_en(w64), .address(addr64),
        .write_data(wdata64), .read_data(rdata64), .ready(rdy64), .SRAM_UB_N(ub64), .SRAM_LB_N(lb64),
        .SRAM_CE_N(ce64), .SRAM_OE_N(oe64), .SRAM_WE_N(we64), .SRAM_ADDR(sa64), .SRAM_DQ(dq64)
    );

    // Asynchronous SRAM devices: drive when output-enabled, capture on clock edges while WE_N is low.
    logic [15:0] sram   [0:1023];
    logic [15:0] sram64 [0:63];
    assign dq   = (!oe_n && we_n) ? sram[sa[9:0]]   : 16'hzzzz;
    assign dq64 = (!oe64 && we64) ? sram64[sa64[5:0]] : 16'hzzzz;
    always @(posedge clk) if (!we_n) sram[sa[9:0]] <= dq;
    always @(posedge clk) if (!we64) sram64[sa64[5:0]] <= dq64;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: word-addressed memory, last completed read, and the buffer's tag.
    localparam int LAT = 2 * (2 + 1) + 1;
    logic [31:0] ref_mem [0:31];
    logic [31:0] ref_last_rd;
    bit          buf_v;
    int          buf_w;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [31:0] rd;
        int          lat;
        int          word;
    } exp_t;
    exp_t exp_q[$];

    bit   mon_en = 1'b0;
    int   cyc    = 0;
    exp_t e;

    // Monitor: counts request cycles and compares against the scoreboard whenever ready is seen.
    always @(negedge clk) begin
        if (mon_en && (r_en || w_en)) begin
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 64'(cyc), 64'(e.lat));
                    chk("read_data", 64'(rdata), 64'(e.rd));
                    if (e.wr) begin
                        chk("sram_lo", 64'(sram[2*e.word]),     64'(e.data[15:0]));
                        chk("sram_hi", 64'(sram[2*e.word + 1]), 64'(e.data[31:16]));
                    end
                end
                cyc = 0;
            end else begin
                cyc++;
            end
        end
    end

    task automatic do_txn(input bit rd, input bit wr, input int word, input logic [31:0] data);
        exp_t x;
        bit   seen = 1'b0;
        x.wr   = wr;
        x.word = word;
        x.data = data;
        x.lat  = LAT;
        if (wr) begin
            ref_mem[word] = data;
        end else begin
`ifdef SRAM_READ_BUFFER_EN
            if (buf_v && buf_w == word) x.lat = 0;
            buf_v = 1'b1;
            buf_w = word;
`endif
            ref_last_rd = ref_mem[word];
        end
        x.rd = ref_last_rd;
        exp_q.push_back(x);
        r_en  = rd;
        w_en  = wr;
        addr  = 32'(1024 + 4 * word);
        wdata = data;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rdy;
        end
        if (!seen) begin
            chk("ready_timeout", 64'd0, 64'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        r_en = 1'b0;
        w_en = 1'b0;
    endtask

    task automatic txn64(input bit wr, input logic [63:0] data, input logic [63:0] exp_rd);
        int  lat  = 0;
        bit  seen = 1'b0;
        r64     = !wr;
        w64     = wr;
        addr64  = 32'd1032;
        wdata64 = data;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rdy64) seen = 1'b1;
            else lat++;
        end
        chk("lat64", 64'(lat), 64'd5);
        chk("rdata64", rdata64, exp_rd);
        @(posedge clk);
        #1;
        r64 = 1'b0;
        w64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] <= 16'h0000;
        for (int i = 0; i < 64; i++)   sram64[i] <= 16'h0000;
        for (int i = 0; i < 32; i++)   ref_mem[i] = 32'h0;
        ref_last_rd = 32'h0;
        buf_v = 1'b0;
        buf_w = 0;
        reset = 1'b0;
        r_en = 1'b0; w_en = 1'b0; addr = 32'h0; wdata = 32'h0;
        r64 = 1'b0;  w64 = 1'b0;  addr64 = 32'h0; wdata64 = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(rdy), 64'd1);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_we_n", 64'(we_n), 64'd1);
        chk("rst_oe_n", 64'(oe_n), 64'd0);
        chk("rst_addr", 64'(sa), 64'd0);
        chk("rst_tie", 64'({ub_n, lb_n, ce_n}), 64'd0);
        chk("rst64_ready", 64'(rdy64), 64'd1);
        chk("rst64_rdata", rdata64, 64'd0);
        chk("rst64_strobes", 64'({we64, oe64}), 64'b10);
        chk("rst64_addr", 64'(sa64), 64'd0);
        chk("rst64_tie", 64'({ub64, lb64, ce64}), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Abort a write after its first beat has landed.
        w_en  = 1'b1;
        addr  = 32'(1024 + 80);
        wdata = 32'hCAFEF00D;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_we_n", 64'(we_n), 64'd1);
        chk("abort_oe_n", 64'(oe_n), 64'd0);
        chk("abort_ready", 64'(rdy), 64'd1);
        w_en = 1'b0;
        chk("abort_sram_lo", 64'(sram[40]), 64'h0000F00D);
        chk("abort_sram_hi", 64'(sram[41]), 64'h0);
        ref_mem[20] = 32'h0000F00D;
        buf_v = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        do_txn(1'b1, 1'b0, 20, 32'h0);

        do_txn(1'b0, 1'b1, 0, 32'hDEADBEEF);
        do_txn(1'b1, 1'b0, 0, 32'h0);
        do_txn(1'b1, 1'b1, 1, 32'h11112222);
        do_txn(1'b1, 1'b0, 0, 32'h0);
        do_txn(1'b0, 1'b1, 0, 32'h00000005);
        do_txn(1'b1, 1'b0, 0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            do_txn(sel != 1, sel != 0, $urandom_range(0, 15), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        txn64(1'b1, 64'h0123456789ABCDEF, 64'h0);
        chk("sram64_4", 64'(sram64[4]), 64'hCDEF);
        chk("sram64_5", 64'(sram64[5]), 64'h89AB);
        chk("sram64_6", 64'(sram64[6]), 64'h4567);
        chk("sram64_7", 64'(sram64[7]), 64'h0123);
        txn64(1'b0, 64'h0, 64'h0123456789ABCDEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
